// File: rtl/reg_rename_file_pkg.sv
// Shared widths and types for the architectural register file and rename table.
package reg_rename_file_pkg;

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned WORD_W = 32;

    typedef logic [IDX_W-1:0]  reg_idx_t;
    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/rf_read_port.sv
// One rs lookup: value-or-tag from the register state, combinational.
// RF_COMMIT_BYPASS_EN adds a same-cycle forward of a matching commit.
module rf_read_port
    import reg_rename_file_pkg::*;
#(
    parameter int unsigned ROB_LOG = 4,
    parameter int unsigned NREG    = 32
) (
    input  reg_idx_t                       index,
    input  logic [NREG-1:0][WORD_W-1:0]    values,
    input  logic [NREG-1:0]                busy_vec,
    input  logic [NREG-1:0][ROB_LOG-1:0]   tags,
`ifdef RF_COMMIT_BYPASS_EN
    input  logic                           commit_en,
    input  logic [ROB_LOG-1:0]             commit_tag,
    input  word_t                          commit_value,
`endif
    output logic                           busy,
    output logic [ROB_LOG-1:0]             tag,
    output word_t                          value
);

    always_comb begin
        busy  = busy_vec[index];
        tag   = tags[index];
        value = values[index];
        if (index == '0) begin
            busy  = 1'b0;
            value = '0;
        end
`ifdef RF_COMMIT_BYPASS_EN
        // Only the commit that still owns the rename may forward its value.
        if (index != '0 && busy_vec[index] && commit_en && tags[index] == commit_tag) begin
            busy  = 1'b0;
            value = commit_value;
        end
`endif
    end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file plus rename table, fed by ROB commit/flush.
// Define RF_COMMIT_BYPASS_EN to forward a matching commit to lookups in the same cycle.
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int unsigned ROB_LOG = 4,
    parameter int unsigned NREG    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               issue_valid,
    input  logic [4:0]         issue_dest,
    input  logic [ROB_LOG-1:0] issue_RobId,
    input  logic [4:0]         rs1_index,
    output logic               rs1_busy,
    output logic [ROB_LOG-1:0] rs1_tag,
    output logic [31:0]        rs1_value,
    input  logic [4:0]         rs2_index,
    output logic               rs2_busy,
    output logic [ROB_LOG-1:0] rs2_tag,
    output logic [31:0]        rs2_value,
    input  logic               reg_enable,
    input  logic [4:0]         reg_index,
    input  logic [ROB_LOG-1:0] reg_RobId,
    input  logic [31:0]        reg_value,
    input  logic               jump_flag
);

    logic [NREG-1:0][WORD_W-1:0]  value_q, value_d;
    logic [NREG-1:0]              busy_q, busy_d;
    logic [NREG-1:0][ROB_LOG-1:0] tag_q, tag_d;

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (rdy) begin
            if (reg_enable && reg_index != '0) begin
                value_d[reg_index] = reg_value;
                // A younger rename keeps the register busy.
                if (tag_q[reg_index] == reg_RobId) busy_d[reg_index] = 1'b0;
            end
            if (jump_flag) begin
                busy_d = '0;
            end else if (issue_valid && issue_dest != '0) begin
                busy_d[issue_dest] = 1'b1;
                tag_d[issue_dest]  = issue_RobId;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            busy_q  <= '0;
            tag_q   <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

`ifdef RF_COMMIT_BYPASS_EN
    logic commit_en;
    assign commit_en = reg_enable & rdy;
`endif

    rf_read_port #(.ROB_LOG(ROB_LOG), .NREG(NREG)) u_rs1 (
        .index        (rs1_index),
        .values       (value_q),
        .busy_vec     (busy_q),
        .tags         (tag_q),
`ifdef RF_COMMIT_BYPASS_EN
        .commit_en    (commit_en),
        .commit_tag   (reg_RobId),
        .commit_value (reg_value),
`endif
        .busy         (rs1_busy),
        .tag          (rs1_tag),
        .value        (rs1_value)
    );

    rf_read_port #(.ROB_LOG(ROB_LOG), .NREG(NREG)) u_rs2 (
        .index        (rs2_index),
        .values       (value_q),
        .busy_vec     (busy_q),
        .tags         (tag_q),
`ifdef RF_COMMIT_BYPASS_EN
        .commit_en    (commit_en),
        .commit_tag   (reg_RobId),
        .commit_value (reg_value),
`endif
        .busy         (rs2_busy),
        .tag          (rs2_tag),
        .value        (rs2_value)
    );

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed bench for reg_rename_file; expectations follow RF_COMMIT_BYPASS_EN if defined.
module tb_reg_rename_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rdy, issue_valid, reg_enable, jump_flag;
    logic [4:0]  issue_dest, rs1_index, rs2_index, reg_index;
    logic [3:0]  issue_RobId, reg_RobId, rs1_tag, rs2_tag;
    logic        rs1_busy, rs2_busy;
    logic [31:0] rs1_value, rs2_value, reg_value;

    int checks = 0;
    int failures = 0;

    reg_rename_file #(.ROB_LOG(4), .NREG(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .issue_RobId (issue_RobId),
        .rs1_index   (rs1_index),
        .rs1_busy    (rs1_busy),
        .rs1_tag     (rs1_tag),
        .rs1_value   (rs1_value),
        .rs2_index   (rs2_index),
        .rs2_busy    (rs2_busy),
        .rs2_tag     (rs2_tag),
        .rs2_value   (rs2_value),
        .reg_enable  (reg_enable),
        .reg_index   (reg_index),
        .reg_RobId   (reg_RobId),
        .reg_value   (reg_value),
        .jump_flag   (jump_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic idle();
        rdy = 1'b1; issue_valid = 1'b0; issue_dest = '0; issue_RobId = '0;
        reg_enable = 1'b0; reg_index = '0; reg_RobId = '0; reg_value = '0;
        jump_flag = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic issue(input logic [4:0] d, input logic [3:0] t);
        issue_valid = 1'b1; issue_dest = d; issue_RobId = t;
    endtask

    task automatic commit(input logic [4:0] d, input logic [3:0] t, input logic [31:0] v);
        reg_enable = 1'b1; reg_index = d; reg_RobId = t; reg_value = v;
    endtask

    initial begin
        idle();
        rs1_index = 5'd5; rs2_index = 5'd0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, rs1_busy}, 32'd0);
        chk("rst_value", rs1_value, 32'd0);
        chk("rst_tag", {28'd0, rs1_tag}, 32'd0);
        #4 rst_n = 1'b1;
        tick();

        // Issue then commit with matching tag
        issue(5'd5, 4'd3);
        #1 chk("issue_not_visible_same_cycle", {31'd0, rs1_busy}, 32'd0);
        tick();
        chk("issue_busy", {31'd0, rs1_busy}, 32'd1);
        chk("issue_tag", {28'd0, rs1_tag}, 32'd3);
        commit(5'd5, 4'd3, 32'hDEADBEEF);
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("commit_bypass_busy", {31'd0, rs1_busy}, 32'd0);
        chk("commit_bypass_value", rs1_value, 32'hDEADBEEF);
`else
        chk("commit_nobypass_busy", {31'd0, rs1_busy}, 32'd1);
        chk("commit_nobypass_value", rs1_value, 32'd0);
`endif
        tick();
        chk("commit_busy", {31'd0, rs1_busy}, 32'd0);
        chk("commit_value", rs1_value, 32'hDEADBEEF);

        // Async reset mid-run with x5 busy
        issue(5'd5, 4'd3);
        tick();
        chk("pre_reset_busy", {31'd0, rs1_busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, rs1_busy}, 32'd0);
        chk("midrst_value", rs1_value, 32'd0);
        #1 rst_n = 1'b1;
        tick();

        // Younger rename survives older commit
        issue(5'd5, 4'd3); tick();
        issue(5'd5, 4'd7); tick();
        commit(5'd5, 4'd3, 32'd1); tick();
        chk("younger_busy", {31'd0, rs1_busy}, 32'd1);
        chk("younger_tag", {28'd0, rs1_tag}, 32'd7);
        chk("younger_value", rs1_value, 32'd1);

        // Same-cycle issue and commit to x6
        rs2_index = 5'd6;
        issue(5'd6, 4'd9);
        commit(5'd6, 4'd4, 32'd2);
        tick();
        chk("same_cycle_busy", {31'd0, rs2_busy}, 32'd1);
        chk("same_cycle_tag", {28'd0, rs2_tag}, 32'd9);
        chk("same_cycle_value", rs2_value, 32'd2);

        // Flush with link commit and dropped issue
        issue(5'd1, 4'd2); tick();
        jump_flag = 1'b1;
        commit(5'd1, 4'd2, 32'h100);
        issue(5'd8, 4'd5);
        tick();
        rs1_index = 5'd1; rs2_index = 5'd8;
        #1;
        chk("flush_x1_busy", {31'd0, rs1_busy}, 32'd0);
        chk("flush_x1_value", rs1_value, 32'h100);
        chk("flush_x8_busy", {31'd0, rs2_busy}, 32'd0);
        rs1_index = 5'd6; rs2_index = 5'd5;
        #1;
        chk("flush_x6_busy", {31'd0, rs1_busy}, 32'd0);
        chk("flush_x5_busy", {31'd0, rs2_busy}, 32'd0);

        // rdy=0 holds all state
        rdy = 1'b0;
        issue(5'd9, 4'd1);
        commit(5'd6, 4'd9, 32'h1234);
        @(posedge clk); #1;
        rs2_index = 5'd9;
        #1;
        chk("hold_issue_lost", {31'd0, rs2_busy}, 32'd0);
        chk("hold_commit_lost", rs1_value, 32'd2);
        idle();

        // Bypass on matching tag
        issue(5'd7, 4'd5); tick();
        rs1_index = 5'd7;
        commit(5'd7, 4'd5, 32'h55);
        #1;
`ifdef RF_COMMIT_BYPASS_EN
        chk("bypass_busy", {31'd0, rs1_busy}, 32'd0);
        chk("bypass_value", rs1_value, 32'h55);
`else
        chk("nobypass_busy", {31'd0, rs1_busy}, 32'd1);
        chk("nobypass_tag", {28'd0, rs1_tag}, 32'd5);
`endif
        tick();
        chk("x7_after_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x7_after_value", rs1_value, 32'h55);

        // Tag mismatch never forwards
        issue(5'd10, 4'd6); tick();
        rs1_index = 5'd10;
        commit(5'd10, 4'd2, 32'h77);
        #1;
        chk("mismatch_busy", {31'd0, rs1_busy}, 32'd1);
        chk("mismatch_tag", {28'd0, rs1_tag}, 32'd6);
        tick();
        chk("mismatch_after_busy", {31'd0, rs1_busy}, 32'd1);
        chk("mismatch_after_value", rs1_value, 32'h77);

        // x0 is hard-wired
        rs1_index = 5'd0;
        issue(5'd0, 4'd3);
        commit(5'd0, 4'd0, 32'h99);
        #1;
        chk("x0_same_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0_same_value", rs1_value, 32'd0);
        tick();
        chk("x0_after_busy", {31'd0, rs1_busy}, 32'd0);
        chk("x0_after_value", rs1_value, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
